// File: rtl/circulant_transpose_stream_if.sv
// Stream port bundle for circulant_transpose_stream: one word, its
// valid/ready handshake and the per-matrix mode bit.
interface circulant_transpose_stream_if #(
  parameter int WORD_LEN = 32
) ();
  logic [WORD_LEN-1:0] data;
  logic                valid;
  logic                ready;
  logic                mode;

  modport master (output data, output valid, output mode, input  ready);
  modport slave  (input  data, input  valid, input  mode, output ready);
endinterface

// File: rtl/circulant_transpose_stream.sv
// Double-buffered streaming matrix transpose on circulant column storage.
// A[r][c] lives in column memory (r+c) mod MATRIX_DIM at address r, so any
// CPW consecutive rows or columns read back in one cycle without conflicts.
// Optional feature macro: CIRC_TPOSE_LAST_EN adds o_last (end-of-matrix flag).
module circulant_transpose_stream #(
  parameter int MATRIX_DIM = 8,
  parameter int COL_WIDTH  = 8,
  parameter int WORD_LEN   = 32
) (
  input  logic clk,
  input  logic rst_n,
  circulant_transpose_stream_if.slave  i_s,
  circulant_transpose_stream_if.master o_m
`ifdef CIRC_TPOSE_LAST_EN
  ,
  output logic o_last
`endif
);

  localparam int CPW = WORD_LEN / COL_WIDTH;
  localparam int WPR = (CPW > 0) ? MATRIX_DIM / CPW : 1;
  localparam int RW  = $clog2(MATRIX_DIM);
  localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam logic [RW-1:0] ROW_LAST  = RW'(MATRIX_DIM - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WPR - 1);

  if ((MATRIX_DIM < 2) || ((MATRIX_DIM & (MATRIX_DIM - 1)) != 0)) begin : g_bad_dim
    $error("MATRIX_DIM must be a power of two and at least 2");
  end
  if ((CPW < 1) || ((WORD_LEN % COL_WIDTH) != 0)) begin : g_bad_word
    $error("WORD_LEN must be a non-zero multiple of COL_WIDTH");
  end
  if (((CPW & (CPW - 1)) != 0) || (CPW > MATRIX_DIM)) begin : g_bad_cpw
    $error("WORD_LEN/COL_WIDTH must be a power of two not above MATRIX_DIM");
  end

  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_WAIT} rd_state_t;

  logic [COL_WIDTH-1:0] r_mem [2][MATRIX_DIM][MATRIX_DIM];

  logic [RW-1:0] r_wr_row;
  logic [WW-1:0] r_wr_word;
  logic          r_wr_bank;
  logic [1:0]    r_full;
  logic [1:0]    r_mode_bank;

  rd_state_t     r_state, w_state_nxt;
  logic [RW-1:0] r_rd_o;
  logic [WW-1:0] r_rd_w;
  logic          r_iss_bank;
  logic          r_rd_bank;

  logic [COL_WIDTH-1:0] r_col_p1 [MATRIX_DIM];
  logic [RW-1:0]        r_base_p1;
  logic                 r_mode_p1, r_last_p1, r_vld_p1;
  logic [WORD_LEN-1:0]  r_data_p2;
  logic                 r_mode_p2, r_last_p2, r_vld_p2;

  logic                w_wr_fire, w_wr_last, w_stall, w_issue, w_iss_last;
  logic                w_final, w_iss_mode, w_other_full, w_cur_full;
  logic [RW-1:0]       w_base;
  logic [RW-1:0]       w_addr [MATRIX_DIM];
  logic [WORD_LEN-1:0] w_rot;

  assign i_s.ready  = !r_full[r_wr_bank];
  assign w_wr_fire  = i_s.valid && i_s.ready;
  assign w_wr_last  = w_wr_fire && (r_wr_row == ROW_LAST) && (r_wr_word == WORD_LAST);
  assign w_stall    = r_vld_p2 && !o_m.ready;
  assign w_final    = r_vld_p2 && o_m.ready && r_last_p2;
  assign w_iss_last = (r_rd_o == ROW_LAST) && (r_rd_w == WORD_LAST);
  assign w_iss_mode = r_mode_bank[r_iss_bank];
  // A bank whose last word leaves this cycle is not yet free to be re-read.
  assign w_other_full = r_full[~r_iss_bank] && !(w_final && (r_rd_bank == ~r_iss_bank));
  assign w_cur_full   = r_full[r_iss_bank]  && !(w_final && (r_rd_bank == r_iss_bank));

  // Scatter each incoming lane into its circulant column at address = row.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int k = 0; k < CPW; k++) begin
        r_mem[r_wr_bank][RW'(int'(r_wr_row) + int'(r_wr_word) * CPW + k)][r_wr_row]
          <= i_s.data[k*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // Write counters, write bank pointer and the mode latched on each matrix's first word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_row    <= '0;
      r_wr_word   <= '0;
      r_wr_bank   <= 1'b0;
      r_mode_bank <= '0;
    end else if (w_wr_fire) begin
      if ((r_wr_row == '0) && (r_wr_word == '0)) r_mode_bank[r_wr_bank] <= i_s.mode;
      if (r_wr_word == WORD_LAST) begin
        r_wr_word <= '0;
        r_wr_row  <= r_wr_row + 1'b1;
      end else begin
        r_wr_word <= r_wr_word + 1'b1;
      end
      if (w_wr_last) r_wr_bank <= ~r_wr_bank;
    end
  end

  // Bank full flags: set by the last write, cleared by the last output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_wr_last && (r_wr_bank == 1'(b)))     r_full[b] <= 1'b1;
        else if (w_final && (r_rd_bank == 1'(b)))  r_full[b] <= 1'b0;
      end
    end
  end

  // Read FSM next state; RUN chains straight into the other bank when it is ready.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      RD_IDLE: if (r_full[r_iss_bank]) w_state_nxt = RD_RUN;
      RD_RUN: begin
        if (!w_stall) begin
          w_issue = 1'b1;
          if (w_iss_last) w_state_nxt = w_other_full ? RD_RUN : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (w_cur_full)   w_state_nxt = RD_RUN;
        else if (w_final) w_state_nxt = RD_IDLE;
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM state, issue counters, issue bank and drain bank pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RD_IDLE;
      r_rd_o     <= '0;
      r_rd_w     <= '0;
      r_iss_bank <= 1'b0;
      r_rd_bank  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        if (r_rd_w == WORD_LAST) begin
          r_rd_w <= '0;
          r_rd_o <= r_rd_o + 1'b1;
        end else begin
          r_rd_w <= r_rd_w + 1'b1;
        end
        if (w_iss_last) r_iss_bank <= ~r_iss_bank;
      end
      if (w_final) r_rd_bank <= ~r_rd_bank;
    end
  end

  // Per-column read address: the row of the lane that column feeds.
  always_comb begin
    w_base = RW'(int'(r_rd_o) + int'(r_rd_w) * CPW);
    for (int j = 0; j < MATRIX_DIM; j++) begin
      w_addr[j] = r_rd_o;
      if (w_iss_mode) w_addr[j] = RW'(int'(r_rd_w) * CPW + int'(RW'(j - int'(w_base))));
    end
  end

  // ---- stage 1: registered column memory read ----
  // Capture every column plus the rotation base for the stage-2 lane select.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      for (int j = 0; j < MATRIX_DIM; j++) r_col_p1[j] <= r_mem[r_iss_bank][j][w_addr[j]];
      r_base_p1 <= w_base;
      r_mode_p1 <= w_iss_mode;
      r_last_p1 <= w_iss_last;
    end
  end

  // Stage-1 valid advances only when the output is not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_vld_p1 <= 1'b0;
    else if (!w_stall) r_vld_p1 <= w_issue;
  end

  // ---- stage 2: rotate columns into lanes ----
  // Lane k comes from column (base+k) mod MATRIX_DIM.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < CPW; k++) w_rot[k*COL_WIDTH +: COL_WIDTH] = r_col_p1[RW'(int'(r_base_p1) + k)];
  end

  // Output register; holds its word and mode while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_mode_p2 <= 1'b0;
      r_last_p2 <= 1'b0;
    end else if (!w_stall) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_data_p2 <= w_rot;
        r_mode_p2 <= r_mode_p1;
        r_last_p2 <= r_last_p1;
      end
    end
  end

  assign o_m.data  = r_data_p2;
  assign o_m.valid = r_vld_p2;
  assign o_m.mode  = r_mode_p2;
`ifdef CIRC_TPOSE_LAST_EN
  assign o_last    = r_vld_p2 && r_last_p2;
`endif

endmodule
